uart_msg_packer: RTL and testbench

UART_MSG_PACKER -- requirements
Module: uart_msg_packer

---
 rtl/sha_pkg.sv | 7 +
 rtl/uart_msg_packer.sv | 73 +++++++
 tb/tb_uart_msg_packer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 block width, packer FSM states and default message limit.
package sha_pkg;
  localparam int SHA_BLOCK_W = 512;
  localparam int BLK_BYTES = SHA_BLOCK_W / 8;
  localparam int DEF_MAX_BYTES = 55;
  typedef enum logic [1:0] {IDLE, COLLECT, PAD, OUT} state_t;
endpackage

// File: rtl/uart_msg_packer.sv
// uart_msg_packer: collects UART bytes into one SHA-256 padded 512-bit block.
module uart_msg_packer
  import sha_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter bit TERM_EN = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_rd,
  input  logic                   msg_end,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [SHA_BLOCK_W-1:0] blk_data,
  output logic [5:0]             msg_len,
  output logic                   overflow,
  output logic                   busy
);
  localparam logic [5:0] MAX_L = 6'(MAX_BYTES);
  state_t      r_state;
  logic [7:0]  r_buf [BLK_BYTES];
  logic [5:0]  r_len;
  logic        r_ovf;
  logic        w_collect, w_pop, w_term, w_store, w_drop, w_end;
  logic [63:0] w_bits;
  assign w_collect = (r_state == IDLE) || (r_state == COLLECT);
  assign w_pop     = w_collect && byte_valid;
  assign w_term    = TERM_EN && (byte_data == TERM_CHAR);
  assign w_store   = w_pop && !w_term && (r_len < MAX_L);
  assign w_drop    = w_pop && !w_term && !(r_len < MAX_L);
  // A terminator byte closes the message exactly like an msg_end pulse.
  assign w_end     = w_collect && (msg_end || (w_pop && w_term));
  assign w_bits    = {55'd0, r_len, 3'd0};
  assign byte_rd   = w_pop && !rst;
  assign blk_valid = r_state == OUT;
  assign busy      = (r_state == PAD) || (r_state == OUT);
  assign msg_len   = r_len;
  assign overflow  = r_ovf;
  genvar g;
  for (g = 0; g < BLK_BYTES; g++) begin : g_blk
    assign blk_data[SHA_BLOCK_W-1-8*g -: 8] = r_buf[g];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < BLK_BYTES; i++) r_buf[i] <= '0;
    end else if (w_collect) begin
      if (w_store) begin
        r_buf[r_len] <= byte_data;
        r_len        <= r_len + 6'd1;
      end
      if (w_drop) r_ovf <= 1'b1;
      else if (w_store && r_state == IDLE) r_ovf <= 1'b0;
      r_state <= w_end ? PAD : (w_store ? COLLECT : r_state);
    end else if (r_state == PAD) begin
      // Stale bytes from an earlier longer message are overwritten with zeros here.
      for (int i = 0; i < 56; i++) begin
        if (i == int'(r_len)) r_buf[i] <= 8'h80;
        else if (i > int'(r_len)) r_buf[i] <= 8'h00;
      end
      for (int i = 0; i < 8; i++) r_buf[56+i] <= w_bits[63-8*i -: 8];
      r_state <= OUT;
    end else if (blk_ready) begin
      r_state <= IDLE;
      r_len   <= '0;
    end
  end
endmodule

// File: tb/tb_uart_msg_packer.sv
// tb_uart_msg_packer: directed checks of padding, overflow, backpressure and reset.
module tb_uart_msg_packer;
  logic         clk = 1'b0;
  logic         rst, byte_valid, byte_rd, msg_end, blk_valid, blk_ready, overflow, busy;
  logic [7:0]   byte_data;
  logic [511:0] blk_data;
  logic [5:0]   msg_len;
  int n_chk = 0, n_err = 0, n_pop = 0;
  localparam logic [511:0] BLK_ABC   = {24'h616263, 8'h80, 416'd0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {8'h80, 440'd0, 64'd0};
  localparam logic [511:0] BLK_A     = {8'h61, 8'h80, 432'd0, 64'h8};
  localparam logic [511:0] BLK_55A   = {{55{8'h61}}, 8'h80, 64'h1B8};
  always #5 clk = ~clk;
  uart_msg_packer dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_rd(byte_rd), .msg_end(msg_end), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .msg_len(msg_len),
    .overflow(overflow), .busy(busy)
  );
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] b, input logic e);
    @(negedge clk);
    byte_valid = v;
    byte_data = b;
    msg_end = e;
    #1 if (byte_rd) n_pop++;
    @(posedge clk);
  endtask
  task automatic done(input string tag, input logic [511:0] eb, input logic [5:0] el, input logic eo);
    @(negedge clk);
    byte_valid = 1'b0;
    msg_end = 1'b0;
    chk({tag, "_pad_busy"}, busy, 1);
    chk({tag, "_pad_valid"}, blk_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, blk_valid, 1);
    chk({tag, "_data"}, blk_data, eb);
    chk({tag, "_len"}, msg_len, el);
    chk({tag, "_ovf"}, overflow, eo);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk({tag, "_idle_valid"}, blk_valid, 0);
    chk({tag, "_idle_len"}, msg_len, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask
  initial begin
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h55; msg_end = 1'b0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd", byte_rd, 0);
    chk("rst_valid", blk_valid, 0);
    chk("rst_len", msg_len, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", blk_data, 0);
    rst = 1'b0;
    byte_valid = 1'b0;
    step(1, 8'h61, 0);
    step(1, 8'h62, 0);
    step(1, 8'h63, 1);
    done("abc", BLK_ABC, 6'd3, 1'b0);
    step(0, 8'h00, 1);
    done("empty", BLK_EMPTY, 6'd0, 1'b0);
    n_pop = 0;
    for (int i = 0; i < 55; i++) step(1, 8'h61, 0);
    step(1, 8'h0D, 0);
    chk("cr55_pops", n_pop, 56);
    done("cr55", BLK_55A, 6'd55, 1'b0);
    n_pop = 0;
    for (int i = 0; i < 57; i++) step(1, 8'h61, 0);
    step(0, 8'h00, 1);
    chk("ovf57_pops", n_pop, 57);
    done("ovf57", BLK_55A, 6'd55, 1'b1);
    chk("ovf_sticky", overflow, 1);
    step(1, 8'h61, 1);
    @(negedge clk);
    msg_end = 1'b0;
    chk("bp_ovf_clr", overflow, 0);
    chk("bp_pad_rd", byte_rd, 0);
    @(negedge clk);
    chk("bp_out_data", blk_data, BLK_A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rd", byte_rd, 0);
      chk("bp_valid", blk_valid, 1);
      chk("bp_stable", blk_data, BLK_A);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk("bp_idle_valid", blk_valid, 0);
    chk("bp_idle_rd", byte_rd, 1);
    chk("bp_idle_len", msg_len, 0);
    byte_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 8'h31 + 8'(i), 0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("mid_len", msg_len, 4);
    #2 rst = 1'b1;
    byte_valid = 1'b1;
    #1;
    chk("mid_rst_len", msg_len, 0);
    chk("mid_rst_rd", byte_rd, 0);
    chk("mid_rst_data", blk_data, 0);
    chk("mid_rst_valid", blk_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    step(1, 8'h61, 1);
    done("post_rst", BLK_A, 6'd1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
